sisc_dmem_resp: RTL and testbench

SISC_DMEM_RESP -- requirements
Module: sisc_dmem_resp

---
 rtl/sisc_pkg.sv | 30 +++
 rtl/sisc_dmem_resp_if.sv | 21 ++
 rtl/sisc_dmem_array.sv | 26 ++
 rtl/sisc_dmem_resp.sv | 127 ++++++++++++
 tb/tb_sisc_dmem_resp.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: instruction opcodes, data-memory op encodings and
// the data-memory responder FSM states.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'h0;
  localparam logic [3:0] LOD    = 4'h1;
  localparam logic [3:0] STR    = 4'h2;
  localparam logic [3:0] SWP    = 4'h3;
  localparam logic [3:0] BRA    = 4'h4;
  localparam logic [3:0] BRR    = 4'h5;
  localparam logic [3:0] BNE    = 4'h6;
  localparam logic [3:0] BNR    = 4'h7;
  localparam logic [3:0] ALU_OP = 4'h8;
  localparam logic [3:0] HLT    = 4'hF;

  typedef enum logic [1:0] {
    OP_LOD = 2'b00,
    OP_STR = 2'b01,
    OP_SWP = 2'b10,
    OP_RSV = 2'b11
  } dmem_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRmw,
    StResp
  } dmem_state_e;

endpackage

// File: rtl/sisc_dmem_resp_if.sv
// Request/response bus between the SISC control FSM and the data memory.
interface sisc_dmem_resp_if;
  logic        req;
  logic [1:0]  op;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, op, addr, wdata,
    input  busy, ack, rdata, err
  );

  modport slave (
    input  req, op, addr, wdata,
    output busy, ack, rdata, err
  );
endinterface

// File: rtl/sisc_dmem_array.sv
// Synchronous single-port 32-bit RAM; a write cycle leaves the read register untouched.
module sisc_dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sisc_dmem_resp.sv
// SISC data-memory responder: accepts one LOD/STR/SWP at a time, models a fixed
// access latency and returns a one-cycle ack with registered read data.
module sisc_dmem_resp
  import sisc_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned DEPTH    = 256
) (
  input logic              clk,
  input logic              rst_f,
  sisc_dmem_resp_if.slave  bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYC - 1);

  dmem_state_e   state_q;
  dmem_op_e      op_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [3:0]    cnt_q;
  logic          busy_q;
  logic          ack_q;
  logic          err_q;

  logic [AW-1:0] bus_idx;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_rdata;

  assign bus_idx = AW'(32'(bus.addr) % DEPTH);

  // The RAM reads the incoming address while idle so the word is already on
  // its output during the first wait cycle, even when WAIT_CYC is 1.
  always_comb begin
    ram_addr = addr_q;
    ram_we   = 1'b0;
    unique case (state_q)
      StIdle:  ram_addr = bus_idx;
      StWait:  ram_we = (cnt_q == 4'd0) && (op_q == OP_STR);
      StRmw:   ram_we = 1'b1;
      default: ;
    endcase
    if (rst_f) begin
      ram_we = 1'b0;
    end
  end

  sisc_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= StIdle;
      op_q    <= OP_LOD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            op_q    <= dmem_op_e'(bus.op);
            addr_q  <= bus_idx;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (dmem_op_e'(bus.op) == OP_RSV) begin
              state_q <= StResp;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            if (op_q == OP_SWP) begin
              state_q <= StRmw;
            end else begin
              state_q <= StResp;
              ack_q   <= 1'b1;
              if (op_q == OP_LOD) begin
                rdata_q <= ram_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // RAM output still holds the pre-write word while the write is issued.
        StRmw: begin
          state_q <= StResp;
          ack_q   <= 1'b1;
          rdata_q <= ram_rdata;
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_sisc_dmem_resp.sv
// Scoreboard bench for sisc_dmem_resp: a WAIT_CYC=2 and a WAIT_CYC=1 instance.
module tb_sisc_dmem_resp;
  import sisc_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_f = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic        req_s   [2];
  logic [1:0]  op_s    [2];
  logic [7:0]  addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        busy_w  [2];
  logic        ack_w   [2];
  logic [31:0] rdata_w [2];
  logic        err_w   [2];

  exp_t sb_q [2][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sisc_dmem_resp_if bus0 ();
  sisc_dmem_resp_if bus1 ();

  assign bus0.req = req_s[0];
  assign bus0.op = op_s[0];
  assign bus0.addr = addr_s[0];
  assign bus0.wdata = wdata_s[0];
  assign bus1.req = req_s[1];
  assign bus1.op = op_s[1];
  assign bus1.addr = addr_s[1];
  assign bus1.wdata = wdata_s[1];
  assign busy_w[0] = bus0.busy;
  assign ack_w[0] = bus0.ack;
  assign rdata_w[0] = bus0.rdata;
  assign err_w[0] = bus0.err;
  assign busy_w[1] = bus1.busy;
  assign ack_w[1] = bus1.ack;
  assign rdata_w[1] = bus1.rdata;
  assign err_w[1] = bus1.err;

  sisc_dmem_resp #(.WAIT_CYC(2), .DEPTH(256)) u_dut0 (.clk(clk), .rst_f(rst_f), .bus(bus0));
  sisc_dmem_resp #(.WAIT_CYC(1), .DEPTH(256)) u_dut1 (.clk(clk), .rst_f(rst_f), .bus(bus1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match the oldest expected response, including its cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack_w[i] === 1'b1) begin
        if (sb_q[i].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack inst%0d: got ack at cycle %0d expected none", i, cyc);
        end else begin
          mon_e = sb_q[i].pop_front();
          chk({mon_e.name, "_ack_cycle"}, cyc, mon_e.cyc);
          chk({mon_e.name, "_rdata"}, rdata_w[i], mon_e.rdata);
          chk({mon_e.name, "_err"}, {31'd0, err_w[i]}, {31'd0, mon_e.err});
        end
      end
    end
  end

  task automatic wait_drain(input int i, input string nm);
    int n;
    n = 0;
    while (sb_q[i].size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q[i].size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no ack after %0d cycles expected ack", nm, n);
      sb_q[i].delete();
    end
  endtask

  // lat is the ack cycle counted from the acceptance edge (cycle 1 follows it).
  task automatic issue(input int i, input logic [1:0] o, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee,
                       input int lat, input string nm);
    exp_t e;
    @(negedge clk);
    req_s[i] = 1'b1;
    op_s[i] = o;
    addr_s[i] = a;
    wdata_s[i] = d;
    @(posedge clk);
    #1;
    req_s[i] = 1'b0;
    e.rdata = er;
    e.err = ee;
    e.cyc = cyc + lat - 1;
    e.name = nm;
    sb_q[i].push_back(e);
    chk({nm, "_busy"}, {31'd0, busy_w[i]}, 32'd1);
    wait_drain(i, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int a;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0;
      op_s[i] = 2'b00;
      addr_s[i] = 8'h00;
      wdata_s[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst_f = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", {31'd0, busy_w[i]}, 32'd0);
      chk("reset_ack", {31'd0, ack_w[i]}, 32'd0);
      chk("reset_err", {31'd0, err_w[i]}, 32'd0);
      chk("reset_rdata", rdata_w[i], 32'd0);
    end

    // WAIT_CYC=2: LOD/STR ack at cycle 3, SWP at 4, reserved at 1
    issue(0, OP_STR, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3, "str10");
    issue(0, OP_LOD, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, "lod10");
    issue(0, OP_STR, 8'h20, 32'h5,        32'hDEADBEEF, 1'b0, 3, "str20");
    issue(0, OP_SWP, 8'h20, 32'h9,        32'h5,        1'b0, 4, "swp20");
    issue(0, OP_LOD, 8'h20, 32'h0,        32'h9,        1'b0, 3, "lod20");
    issue(0, OP_RSV, 8'h20, 32'hFFFF,     32'h9,        1'b1, 1, "rsv");
    issue(0, OP_LOD, 8'h20, 32'h0,        32'h9,        1'b0, 3, "lod20_after_rsv");
    issue(0, OP_STR, 8'h01, 32'hA5A50001, 32'h9,        1'b0, 3, "str01");

    // req held through cycle 7: accepted at 0 and 4, ignored while busy and in ack cycles
    @(negedge clk);
    req_s[0] = 1'b1;
    op_s[0] = OP_LOD;
    addr_s[0] = 8'h01;
    @(posedge clk);
    #1;
    a = cyc;
    e.rdata = 32'hA5A50001;
    e.err = 1'b0;
    e.cyc = a + 2;
    e.name = "hold_first";
    sb_q[0].push_back(e);
    e.cyc = a + 6;
    e.name = "hold_second";
    sb_q[0].push_back(e);
    repeat (7) @(posedge clk);
    #1 req_s[0] = 1'b0;
    wait_drain(0, "hold");
    repeat (6) @(posedge clk);

    // Reset during the final wait cycle of a store drops the write and the ack
    issue(0, OP_STR, 8'h30, 32'h11112222, 32'hA5A50001, 1'b0, 3, "str30");
    @(negedge clk);
    req_s[0] = 1'b1;
    op_s[0] = OP_STR;
    addr_s[0] = 8'h30;
    wdata_s[0] = 32'hBAD0BAD0;
    @(posedge clk);
    #1 req_s[0] = 1'b0;
    @(posedge clk);
    #1 rst_f = 1'b1;
    @(posedge clk);
    #1 rst_f = 1'b0;
    chk("rst_mid_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("rst_mid_ack", {31'd0, ack_w[0]}, 32'd0);
    chk("rst_mid_rdata", rdata_w[0], 32'd0);
    repeat (6) @(posedge clk);
    issue(0, OP_LOD, 8'h30, 32'h0,  32'h11112222, 1'b0, 3, "lod30_after_rst");
    issue(0, OP_SWP, 8'h30, 32'h33, 32'h11112222, 1'b0, 4, "swp30_a");
    issue(0, OP_SWP, 8'h30, 32'h44, 32'h33,       1'b0, 4, "swp30_b");
    issue(0, OP_LOD, 8'h30, 32'h0,  32'h44,       1'b0, 3, "lod30_final");
    issue(0, OP_LOD, 8'h10, 32'h0,  32'hDEADBEEF, 1'b0, 3, "lod10_after_rst");

    // WAIT_CYC=1: LOD/STR ack at cycle 2, SWP at 3; top word address
    issue(1, OP_STR, 8'hFF, 32'h12345678, 32'h0,        1'b0, 2, "w1_strff");
    issue(1, OP_LOD, 8'hFF, 32'h0,        32'h12345678, 1'b0, 2, "w1_lodff");
    issue(1, OP_SWP, 8'hFF, 32'h87654321, 32'h12345678, 1'b0, 3, "w1_swpff");
    issue(1, OP_RSV, 8'hFF, 32'h0,        32'h12345678, 1'b1, 1, "w1_rsv");
    issue(1, OP_LOD, 8'hFF, 32'h0,        32'h87654321, 1'b0, 2, "w1_lodff_b");

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
